// File: rtl/ibex_pkg.sv
// Shared LSU types: FSM state encoding, access-size codes and the split-access test.
// The *_MIS states exist only when IBEX_LSU_MISALIGNED_EN is defined.
package ibex_pkg;

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
`ifdef IBEX_LSU_MISALIGNED_EN
    WAIT_GNT_MIS    = 3'd1,
    WAIT_RVALID_MIS = 3'd2,
`endif
    WAIT_GNT        = 3'd3,
    WAIT_RVALID     = 3'd4
  } ls_fsm_e;

  localparam logic [1:0] LSU_WORD = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_BYTE = 2'b10;

  // Reserved size 2'b11 behaves as a word.
  function automatic logic lsu_is_split(input logic [1:0] typ, input logic [1:0] off);
    logic word;
    word = (typ == LSU_WORD) || (typ == 2'b11);
    return (word && (off != 2'b00)) || ((typ == LSU_HALF) && (off == 2'b11));
  endfunction

endpackage

// File: rtl/ibex_lsu_data_align.sv
// Combinational LSU datapath: byte enables, store-data rotation and
// load-data extraction/extension, possibly spanning two bus words.
module ibex_lsu_data_align
  import ibex_pkg::*;
(
  input  logic [1:0]  type_i,
  input  logic [1:0]  offset_i,
  input  logic        second_i,
  input  logic        split_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_first_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  mask;
  logic [7:0]  mask_sh;
  logic [55:0] rd_cat;
  logic [31:0] rd_al;

  always_comb begin
    case (type_i)
      LSU_HALF: mask = 4'b0011;
      LSU_BYTE: mask = 4'b0001;
      default:  mask = 4'b1111;
    endcase
    // Upper nibble holds the lanes that spill into the next word.
    mask_sh = {4'b0000, mask} << offset_i;
    be_o    = second_i ? mask_sh[7:4] : mask_sh[3:0];

    case (offset_i)
      2'd1:    wdata_o = {wdata_i[23:0], wdata_i[31:24]};
      2'd2:    wdata_o = {wdata_i[15:0], wdata_i[31:16]};
      2'd3:    wdata_o = {wdata_i[7:0],  wdata_i[31:8]};
      default: wdata_o = wdata_i;
    endcase

    // Split loads concatenate the second word above the registered first word.
    rd_cat = split_i ? {rdata_i[23:0], rdata_first_i} : {24'h0, rdata_i};
    case (offset_i)
      2'd1:    rd_al = rd_cat[39:8];
      2'd2:    rd_al = rd_cat[47:16];
      2'd3:    rd_al = rd_cat[55:24];
      default: rd_al = rd_cat[31:0];
    endcase

    case (type_i)
      LSU_HALF: rdata_o = {{16{sign_ext_i & rd_al[15]}}, rd_al[15:0]};
      LSU_BYTE: rdata_o = {{24{sign_ext_i & rd_al[7]}},  rd_al[7:0]};
      default:  rdata_o = rd_al;
    endcase
  end

endmodule

// File: rtl/ibex_load_store_unit.sv
// Load/store unit: one outstanding bus transaction, optional word-crossing splits.
// Split accesses are built when IBEX_LSU_MISALIGNED_EN is defined, otherwise rejected.
module ibex_load_store_unit
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] adder_result_ex_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_busy_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        addr_misaligned_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  ls_fsm_e     ls_fsm_q, ls_fsm_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  type_q, type_d;
  logic        we_q, we_d, sign_ext_q, sign_ext_d, err_q, err_d;

  logic        idle, split, second;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_type;
  logic        cur_we, cur_sext;
  logic        req, resp, mis, err_resp;

  // In IDLE the bus is driven straight from the request; afterwards from the captures.
  assign idle      = (ls_fsm_q == IDLE);
  assign cur_addr  = idle ? adder_result_ex_i : addr_q;
  assign cur_wdata = idle ? lsu_wdata_i       : wdata_q;
  assign cur_type  = idle ? lsu_type_i        : type_q;
  assign cur_we    = idle ? lsu_we_i          : we_q;
  assign cur_sext  = idle ? lsu_sign_ext_i    : sign_ext_q;
  assign split     = lsu_is_split(cur_type, cur_addr[1:0]);

`ifdef IBEX_LSU_MISALIGNED_EN
  assign second = (ls_fsm_q == WAIT_RVALID_MIS) ||
                  (split && ((ls_fsm_q == WAIT_GNT) || (ls_fsm_q == WAIT_RVALID)));
`else
  assign second = 1'b0;
`endif

  ibex_lsu_data_align u_align (
    .type_i        (cur_type),
    .offset_i      (cur_addr[1:0]),
    .second_i      (second),
    .split_i       (split),
    .sign_ext_i    (cur_sext),
    .wdata_i       (cur_wdata),
    .rdata_first_i (rdata_q),
    .rdata_i       (data_rdata_i),
    .be_o          (data_be_o),
    .wdata_o       (data_wdata_o),
    .rdata_o       (lsu_rdata_o)
  );

  always_comb begin
    ls_fsm_d   = ls_fsm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    type_d     = type_q;
    we_d       = we_q;
    sign_ext_d = sign_ext_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req        = 1'b0;
    resp       = 1'b0;
    mis        = 1'b0;
    err_resp   = 1'b0;
    case (ls_fsm_q)
      IDLE: begin
        if (lsu_req_i) begin
          addr_d     = adder_result_ex_i;
          wdata_d    = lsu_wdata_i;
          type_d     = lsu_type_i;
          we_d       = lsu_we_i;
          sign_ext_d = lsu_sign_ext_i;
          err_d      = 1'b0;
`ifdef IBEX_LSU_MISALIGNED_EN
          req = 1'b1;
          if (split) ls_fsm_d = data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
          else       ls_fsm_d = data_gnt_i ? WAIT_RVALID     : WAIT_GNT;
`else
          if (split) begin
            mis  = 1'b1;
            resp = 1'b1;
          end else begin
            req      = 1'b1;
            ls_fsm_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
`endif
        end
      end
`ifdef IBEX_LSU_MISALIGNED_EN
      WAIT_GNT_MIS: begin
        req = 1'b1;
        if (data_gnt_i) ls_fsm_d = WAIT_RVALID_MIS;
      end
      WAIT_RVALID_MIS: begin
        // Second part goes out in the same cycle the first response lands.
        if (data_rvalid_i) begin
          rdata_d  = data_rdata_i;
          err_d    = err_q | data_err_i;
          req      = 1'b1;
          ls_fsm_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
`endif
      WAIT_GNT: begin
        req = 1'b1;
        if (data_gnt_i) ls_fsm_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          resp     = 1'b1;
          err_resp = err_q | data_err_i;
          ls_fsm_d = IDLE;
        end
      end
      default: ls_fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ls_fsm_q   <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      type_q     <= '0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ls_fsm_q   <= ls_fsm_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      type_q     <= type_d;
      we_q       <= we_d;
      sign_ext_q <= sign_ext_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign data_addr_o       = {cur_addr[31:2], 2'b00} + (second ? 32'd4 : 32'd0);
  assign data_we_o         = cur_we;
  assign data_req_o        = req & rst_ni;
  assign lsu_resp_valid_o  = resp & rst_ni;
  assign addr_misaligned_o = mis & rst_ni;
  assign lsu_busy_o        = ~idle & rst_ni;
  assign load_err_o        = err_resp & ~we_q & rst_ni;
  assign store_err_o       = err_resp & we_q & rst_ni;

endmodule

// File: tb/tb_ibex_load_store_unit.sv
// Self-checking bench: vector table of single-part accesses, scoreboard of
// expected responses, and hand sequences for split/reject, busy and reset cases.
module tb_ibex_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0, lsu_sign_ext_i = 1'b0;
  logic [1:0]  lsu_type_i = 2'b00;
  logic [31:0] adder_result_ex_i = '0, lsu_wdata_i = '0;
  logic [31:0] lsu_rdata_o;
  logic        lsu_resp_valid_o, lsu_busy_o, load_err_o, store_err_o, addr_misaligned_o;
  logic        data_req_o, data_we_o;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_rdata_i = '0;

  always #5 clk = ~clk;

  ibex_load_store_unit dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .adder_result_ex_i(adder_result_ex_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_busy_o(lsu_busy_o),
    .load_err_o(load_err_o), .store_err_o(store_err_o),
    .addr_misaligned_o(addr_misaligned_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        lerr;
    logic        serr;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  typ;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdly;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  exp_t sb[$];
  exp_t e_mon;
  vec_t vt[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (lsu_resp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=1 expected=0 at %0t", $time);
      end else begin
        e_mon = sb.pop_front();
        if (e_mon.chk_rd) chk("rdata", lsu_rdata_o, e_mon.rdata);
        chk("load_err", {31'b0, load_err_o}, {31'b0, e_mon.lerr});
        chk("store_err", {31'b0, store_err_o}, {31'b0, e_mon.serr});
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = v.we; lsu_type_i = v.typ; lsu_sign_ext_i = v.sext;
    adder_result_ex_i = v.addr; lsu_wdata_i = v.wdata;
    e.chk_rd = !v.we; e.rdata = v.e_rdata; e.lerr = v.err & !v.we; e.serr = v.err & v.we;
    sb.push_back(e);
    for (int i = 0; i <= v.gdly; i++) begin
      data_gnt_i = (i == v.gdly);
      @(negedge clk);
      chk("req", {31'b0, data_req_o}, 32'd1);
      chk("addr", data_addr_o, v.e_addr);
      chk("be", {28'b0, data_be_o}, {28'b0, v.e_be});
      chk("we", {31'b0, data_we_o}, {31'b0, v.we});
      if (v.we) chk("wdata", data_wdata_o, v.e_wdata);
      @(posedge clk); #1;
      // Request inputs may wander once accepted; the bus must not.
      lsu_req_i = 1'b0; adder_result_ex_i = $urandom; lsu_wdata_i = $urandom;
    end
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = v.rdata; data_err_i = v.err;
    @(negedge clk);
    chk("busy", {31'b0, lsu_busy_o}, 32'd1);
    chk("resp", {31'b0, lsu_resp_valid_o}, 32'd1);
    @(posedge clk); #1;
    data_rvalid_i = 1'b0; data_err_i = 1'b0;
    chk("resp_count", sb.size(), 32'd0);
  endtask

  initial begin
    exp_t e;
    //          we   typ    sx addr          wdata         rdata         g  err e_addr        be       e_wdata       e_rdata
    vt[0]  = '{1'b0, 2'b00, 1'b0, 32'h1000, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'h1000, 4'b1111, 32'h0,        32'hDEADBEEF};
    vt[1]  = '{1'b0, 2'b10, 1'b1, 32'h1003, 32'h0,        32'h80123456, 0, 1'b0, 32'h1000, 4'b1000, 32'h0,        32'hFFFFFF80};
    vt[2]  = '{1'b0, 2'b10, 1'b0, 32'h1003, 32'h0,        32'h80123456, 0, 1'b0, 32'h1000, 4'b1000, 32'h0,        32'h00000080};
    vt[3]  = '{1'b1, 2'b01, 1'b0, 32'h2001, 32'h0000ABCD, 32'h0,        0, 1'b0, 32'h2000, 4'b0110, 32'h00ABCD00, 32'h0};
    vt[4]  = '{1'b0, 2'b01, 1'b1, 32'h2002, 32'h0,        32'h80011234, 3, 1'b0, 32'h2000, 4'b1100, 32'h0,        32'hFFFF8001};
    vt[5]  = '{1'b0, 2'b10, 1'b0, 32'h4001, 32'h0,        32'h00009A00, 0, 1'b0, 32'h4000, 4'b0010, 32'h0,        32'h0000009A};
    vt[6]  = '{1'b1, 2'b10, 1'b0, 32'h5002, 32'h000000EE, 32'h0,        1, 1'b0, 32'h5000, 4'b0100, 32'h00EE0000, 32'h0};
    vt[7]  = '{1'b0, 2'b00, 1'b0, 32'h6000, 32'h0,        32'h0,        1, 1'b1, 32'h6000, 4'b1111, 32'h0,        32'h0};
    vt[8]  = '{1'b1, 2'b00, 1'b0, 32'h7000, 32'h12345678, 32'h0,        0, 1'b1, 32'h7000, 4'b1111, 32'h12345678, 32'h0};
    vt[9]  = '{1'b0, 2'b11, 1'b0, 32'h8000, 32'h0,        32'hCAFEF00D, 0, 1'b0, 32'h8000, 4'b1111, 32'h0,        32'hCAFEF00D};
    vt[10] = '{1'b0, 2'b01, 1'b1, 32'h1001, 32'h0,        32'h00CAFE00, 2, 1'b0, 32'h1000, 4'b0110, 32'h0,        32'hFFFFCAFE};
    vt[11] = '{1'b0, 2'b01, 1'b0, 32'hC000, 32'h0,        32'h12348765, 0, 1'b0, 32'hC000, 4'b0011, 32'h0,        32'h00008765};

    // Reset state, with a request pending on the inputs.
    lsu_req_i = 1'b1; adder_result_ex_i = 32'h1000; data_gnt_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, data_req_o}, 32'd0);
    chk("rst_resp", {31'b0, lsu_resp_valid_o}, 32'd0);
    chk("rst_busy", {31'b0, lsu_busy_o}, 32'd0);
    chk("rst_errs", {30'b0, load_err_o, store_err_o}, 32'd0);
    chk("rst_mis", {31'b0, addr_misaligned_o}, 32'd0);
    @(posedge clk); #1;
    lsu_req_i = 1'b0; data_gnt_i = 1'b0; rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vt[i]);

`ifdef IBEX_LSU_MISALIGNED_EN
    // Split load word 0x3002.
    @(posedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b00; lsu_sign_ext_i = 1'b0;
    adder_result_ex_i = 32'h3002; data_gnt_i = 1'b1;
    e = '{1'b1, 32'h77885566, 1'b0, 1'b0}; sb.push_back(e);
    @(negedge clk);
    chk("split1_addr", data_addr_o, 32'h3000);
    chk("split1_be", {28'b0, data_be_o}, 32'hC);
    @(posedge clk); #1;
    lsu_req_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h5566_0000;
    @(negedge clk);
    chk("split2_req", {31'b0, data_req_o}, 32'd1);
    chk("split2_addr", data_addr_o, 32'h3004);
    chk("split2_be", {28'b0, data_be_o}, 32'h3);
    chk("split_no_early_resp", {31'b0, lsu_resp_valid_o}, 32'd0);
    @(posedge clk); #1;
    data_gnt_i = 1'b0; data_rdata_i = 32'h0000_7788;
    @(negedge clk);
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    chk("split_resp_count", sb.size(), 32'd0);

    // Split store word 0x3001 with an error on the first part.
    @(posedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; adder_result_ex_i = 32'h3001;
    lsu_wdata_i = 32'h11223344; data_gnt_i = 1'b1;
    e = '{1'b0, 32'h0, 1'b0, 1'b1}; sb.push_back(e);
    @(negedge clk);
    chk("sst1_be", {28'b0, data_be_o}, 32'hE);
    chk("sst1_wdata", data_wdata_o, 32'h22334411);
    @(posedge clk); #1;
    lsu_req_i = 1'b0; data_rvalid_i = 1'b1; data_err_i = 1'b1;
    @(negedge clk);
    chk("sst2_req", {31'b0, data_req_o}, 32'd1);
    chk("sst2_addr", data_addr_o, 32'h3004);
    chk("sst2_be", {28'b0, data_be_o}, 32'h1);
    chk("sst2_wdata", data_wdata_o, 32'h22334411);
    @(posedge clk); #1;
    data_gnt_i = 1'b0; data_err_i = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    chk("sst_resp_count", sb.size(), 32'd0);
`else
    // Split accesses are rejected in the request cycle.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0;
      lsu_type_i = (k == 0) ? 2'b00 : 2'b01;
      adder_result_ex_i = (k == 0) ? 32'h3002 : 32'h1003;
      data_gnt_i = 1'b1;
      e = '{1'b0, 32'h0, 1'b0, 1'b0}; sb.push_back(e);
      @(negedge clk);
      chk("rej_req", {31'b0, data_req_o}, 32'd0);
      chk("rej_mis", {31'b0, addr_misaligned_o}, 32'd1);
      chk("rej_resp", {31'b0, lsu_resp_valid_o}, 32'd1);
      @(posedge clk); #1;
      lsu_req_i = 1'b0; data_gnt_i = 1'b0;
      @(negedge clk);
      chk("rej_busy", {31'b0, lsu_busy_o}, 32'd0);
      chk("rej_mis_pulse", {31'b0, addr_misaligned_o}, 32'd0);
      chk("rej_resp_count", sb.size(), 32'd0);
    end
`endif

    // Request while busy is ignored; reset in WAIT_RVALID drops the late rvalid.
    @(posedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b00;
    adder_result_ex_i = 32'h9000; data_gnt_i = 1'b1;
    @(posedge clk); #1;
    adder_result_ex_i = 32'hA000; data_gnt_i = 1'b0;
    @(negedge clk);
    chk("busy_ignore_req", {31'b0, data_req_o}, 32'd0);
    chk("busy_flag", {31'b0, lsu_busy_o}, 32'd1);
    @(posedge clk); #1;
    lsu_req_i = 1'b0; rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("late_rvalid_resp", {31'b0, lsu_resp_valid_o}, 32'd0);
    chk("late_rvalid_busy", {31'b0, lsu_busy_o}, 32'd0);
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;

    run_vec(vt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
